// File: rtl/mem_block_copier.sv
// rtl/mem_block_copier.sv - block copy master for a single-port active-low memory
// Alternates READ/WRITE per word at ascending addresses; abort stops after the current access.
module mem_block_copier #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 4
) (
    input  logic                     iClk,
    input  logic                     iReset,
    input  logic                     iStart,
    input  logic [ADDRESS_WIDTH-1:0] iSrcAddr,
    input  logic [ADDRESS_WIDTH-1:0] iDstAddr,
    input  logic [ADDRESS_WIDTH:0]   iLength,
    input  logic                     iAbort,
    output logic                     oBusy,
    output logic                     oDone,
    output logic                     oAborted,
    output logic [ADDRESS_WIDTH:0]   oCount,
    output logic                     oChipSelect_n,
    output logic                     oRead_n,
    output logic                     oWrite_n,
    output logic [ADDRESS_WIDTH-1:0] oAddress,
    output logic [DATA_WIDTH-1:0]    oWrData,
    input  logic [DATA_WIDTH-1:0]    iRdData
);
    localparam int AW = ADDRESS_WIDTH;
    localparam int DW = DATA_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [AW-1:0] r_src;
    logic [AW-1:0] r_dst;
    logic [AW:0]   r_len;
    logic [AW:0]   r_idx;
    logic [AW:0]   r_count;
    logic          r_aborted;

    logic [AW:0]   w_idx_next;
    logic          w_last;
    logic          w_remain;

    assign w_idx_next = r_idx + 1'b1;
    assign w_last     = (w_idx_next == r_len);
    assign w_remain   = (w_idx_next < r_len);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (iStart) w_next = (iLength == '0) ? S_DONE : S_READ;
            S_READ:  w_next = iAbort ? S_DONE : S_WRITE;
            S_WRITE: w_next = (w_last || iAbort) ? S_DONE : S_READ;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            r_src     <= '0;
            r_dst     <= '0;
            r_len     <= '0;
            r_idx     <= '0;
            r_count   <= '0;
            r_aborted <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (iStart) begin
                        r_src     <= iSrcAddr;
                        r_dst     <= iDstAddr;
                        r_len     <= iLength;
                        r_idx     <= '0;
                        r_count   <= '0;
                        r_aborted <= 1'b0;
                    end
                end
                S_READ: begin
                    if (iAbort && w_remain) r_aborted <= 1'b1;
                end
                S_WRITE: begin
                    r_count <= w_idx_next;
                    // Completing the final word wins over a simultaneous abort.
                    if (!w_last) begin
                        if (iAbort) r_aborted <= 1'b1;
                        else        r_idx     <= w_idx_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign oBusy         = (r_state != S_IDLE);
    assign oDone         = (r_state == S_DONE);
    assign oAborted      = r_aborted;
    assign oCount        = r_count;
    assign oChipSelect_n = !((r_state == S_READ) || (r_state == S_WRITE));
    assign oRead_n       = (r_state != S_READ);
    assign oWrite_n      = (r_state != S_WRITE);
    assign oAddress      = (r_state == S_READ)  ? (r_src + r_idx[AW-1:0]) :
                           (r_state == S_WRITE) ? (r_dst + r_idx[AW-1:0]) : '0;
    assign oWrData       = (r_state == S_WRITE) ? iRdData : {DW{1'b0}};
endmodule

// File: tb/tb_mem_block_copier.sv
// tb/tb_mem_block_copier.sv - randomized self-checking bench for mem_block_copier
// A behavioural memory feeds the DUT; a word-level copy model predicts the result.
module tb_mem_block_copier;
    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] src_addr;
    logic [AW-1:0] dst_addr;
    logic [AW:0]   length;
    logic          abort_in;
    logic          busy;
    logic          done;
    logic          aborted;
    logic [AW:0]   count;
    logic          cs_n;
    logic          rd_n;
    logic          wr_n;
    logic [AW-1:0] addr;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] rd_data;

    logic [DW-1:0] mem [DEPTH];
    int            tests_run;
    int            tests_failed;

    always #5 clk = ~clk;

    mem_block_copier #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
        .iClk(clk), .iReset(rst), .iStart(start), .iSrcAddr(src_addr),
        .iDstAddr(dst_addr), .iLength(length), .iAbort(abort_in),
        .oBusy(busy), .oDone(done), .oAborted(aborted), .oCount(count),
        .oChipSelect_n(cs_n), .oRead_n(rd_n), .oWrite_n(wr_n),
        .oAddress(addr), .oWrData(wr_data), .iRdData(rd_data)
    );

    always @(posedge clk) begin
        if (!cs_n && !rd_n) rd_data <= mem[addr];
        if (!cs_n && !wr_n) mem[addr] <= wr_data;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_aborted"}, aborted, 0);
        check({tag, "_count"}, count, 0);
        check({tag, "_strobes"}, {cs_n, rd_n, wr_n}, 3'b111);
        check({tag, "_addr"}, addr, 0);
        check({tag, "_wrdata"}, wr_data, 0);
    endtask

    // abort_c: cycle after the start edge in which iAbort is held (0 = none).
    task automatic run_copy(input int src, input int dst, input int len,
                            input int abort_c, input bit start_abort);
        logic [DW-1:0] ref_mem [DEPTH];
        int copied, exp_ab, done_exp, done_cyc, pulses, i;
        copied   = len;
        exp_ab   = 0;
        done_exp = 2 * len + 1;
        if (abort_c > 0 && abort_c <= 2 * len) begin
            i        = (abort_c - 1) / 2;
            copied   = (abort_c % 2 == 1) ? i : i + 1;
            exp_ab   = (i + 1 < len) ? 1 : 0;
            done_exp = abort_c + 1;
        end
        for (int j = 0; j < DEPTH; j++) ref_mem[j] = mem[j];
        for (int j = 0; j < copied; j++) ref_mem[(dst + j) % DEPTH] = ref_mem[(src + j) % DEPTH];

        @(negedge clk);
        src_addr = AW'(src);
        dst_addr = AW'(dst);
        length   = (AW + 1)'(len);
        start    = 1'b1;
        abort_in = start_abort;
        done_cyc = 0;
        pulses   = 0;
        for (int k = 1; k <= done_exp + 2 && k <= 40; k++) begin
            @(negedge clk);
            check("rd_wr_exclusive", (!rd_n && !wr_n), 0);
            if (done) begin
                pulses++;
                if (done_cyc == 0) done_cyc = k;
            end
            if (k < done_exp) begin
                check("cs_n", cs_n, 0);
                check("rd_n", rd_n, (k % 2 == 1) ? 0 : 1);
                check("wr_n", wr_n, (k % 2 == 1) ? 1 : 0);
                check("addr", addr, (k % 2 == 1) ? (src + (k - 1) / 2) % DEPTH
                                                 : (dst + k / 2 - 1) % DEPTH);
                check("busy", busy, 1);
            end else if (k == done_exp) begin
                check("done_strobes", {cs_n, rd_n, wr_n}, 3'b111);
                check("done_busy", busy, 1);
            end
            abort_in = (k == abort_c);
            start    = (k < done_exp) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        abort_in = 1'b0;
        start    = 1'b0;
        check("done_cycle", done_cyc, done_exp);
        check("done_pulses", pulses, 1);
        check("count", count, copied);
        check("aborted", aborted, exp_ab);
        check("idle_busy", busy, 0);
        for (int j = 0; j < DEPTH; j++) check("mem", mem[j], ref_mem[j]);
    endtask

    initial begin
        int len, ab;
        tests_run    = 0;
        tests_failed = 0;
        rst      = 1'b1;
        start    = 1'b0;
        abort_in = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        length   = '0;
        rd_data  = '0;
        for (int j = 0; j < DEPTH; j++) mem[j] = $urandom;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        for (int j = 0; j < 4; j++) mem[j] = 32'hA0 + j;
        run_copy(0, 8, 4, 0, 1'b1);
        run_copy(3, 7, 0, 0, 1'b0);
        run_copy(14, 2, 4, 0, 1'b0);
        run_copy(1, 9, 5, 4, 1'b0);
        run_copy(2, 10, 4, 3, 1'b0);
        run_copy(5, 12, 3, 6, 1'b0);
        mem[0] = 32'hDEAD_BEEF;
        run_copy(0, 1, 3, 0, 1'b0);
        run_copy(4, 4, 16, 0, 1'b0);

        @(negedge clk);
        src_addr = 4'd0;
        dst_addr = 4'd8;
        length   = 5'd5;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_reset");
        @(negedge clk);
        rst = 1'b0;
        run_copy(6, 11, 5, 0, 1'b0);

        for (int t = 0; t < 20; t++) begin
            len = $urandom_range(0, 16);
            ab  = (len > 0 && $urandom_range(0, 2) == 0) ? $urandom_range(1, 2 * len) : 0;
            run_copy($urandom_range(0, 15), $urandom_range(0, 15), len, ab,
                     1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
